multi_auto_panner: RTL
======================

MULTI_AUTO_PANNER -- requirements
Module: multi_auto_panner

Interface
REQ-001 Parameter NCH, 4: number of pan channels (1..8).
REQ-002 Parameter PW, 24: phase accumulator width (>=16).
REQ-003 Parameter AW, 12: sine table address width; table file "sine.mem", 2^AW signed 16-bit words.
REQ-004 CLK  in  1  sole clock; all state on rising edge.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 SAMPLE_STB  in  1  one-cycle sample tick starting a frame.
REQ-007 EN  in  1  auto-pan enable.
REQ-008 MODE  in  2  waveform: 0 sine, 1 triangle, 2 square, 3 ramp.
REQ-009 RATE  in  PW  phase increment per frame.
REQ-010 DEPTH  in  16  unsigned modulation depth.
REQ-011 SPREAD  in  16  per-channel phase offset (channel c offset = c*SPREAD, mod 2^16).
REQ-012 PAN_OUT  out  16*NCH  channel c at bits [16c+15:16c]; 0x0000 hard one side, 0x4000 centre, 0x7FFF other side.
REQ-013 PAN_VALID  out  1  one-cycle pulse when PAN_OUT updates.
REQ-014 BUSY  out  1  high while a frame is in progress.
REQ-015 OVERRUN  out  1  sticky: strobe arrived while BUSY.

Function
REQ-016 FSM states IDLE, ACC, LOOKUP, WAIT, CALC, DONE; IDLE->ACC only on SAMPLE_STB.
REQ-017 ACC: latch EN, MODE, DEPTH, SPREAD; acc = EN ? (acc+RATE) mod 2^PW : 0; channel index = 0.
REQ-018 LOOKUP: ph = acc[PW-1:PW-16] + c*SPREAD (16-bit wrap); present ph[15:16-AW] to sine table.
REQ-019 WAIT: one cycle for synchronous table read.
REQ-020 Wave w (signed 16): sine = table data; triangle: u<0x8000 ? 2u-0x8000 : 0x7FFF-2(u-0x8000); square: u<0x8000 ? 0x7FFF : 0x8000; ramp: u XOR 0x8000; u = ph.
REQ-021 CALC: off = (w * {0,DEPTH}) >>> 17 (arithmetic, 33-bit product); pan = 0x4000+off, clamped to [0x0000,0x7FFF]; EN latched low gives pan = 0x4000; written to shadow slot c.
REQ-022 CALC->LOOKUP with c+1 if c<NCH-1, else ->DONE.
REQ-023 DONE: copy all shadow slots to PAN_OUT, PAN_VALID=1 for this cycle only, ->IDLE.
REQ-024 Latency: strobe sampled in cycle T gives PAN_VALID in cycle T+2+3*NCH (T+14 for NCH=4).
REQ-025 BUSY=1 in every state except IDLE.
REQ-026 SAMPLE_STB in any non-IDLE state ignored (no queueing) and sets OVERRUN; current frame unaffected.
REQ-027 Input changes mid-frame do not affect that frame; RATE sampled only in ACC.
REQ-028 PAN_OUT holds between DONE cycles; accumulator wraps modulo 2^PW silently.

Reset
REQ-029 RESET dominates any state: FSM=IDLE, acc=0, c=0, every PAN_OUT channel and shadow slot = 0x4000, PAN_VALID=0, OVERRUN=0.
REQ-030 Frame in progress at RESET is abandoned; no PAN_VALID is produced for it.
REQ-031 First strobe after reset behaves exactly as from power-up.

Structure
REQ-032 Package panner_pkg holds the mode enum, FSM state enum and PAN_CENTER=16'h4000.
REQ-033 Sub-module lfo_wave holds the sine table (existing rom block) and the MODE shaping of REQ-020.
REQ-034 One multiplier, time-shared across channels; no per-channel arithmetic duplication.

Verification (NCH=4, PW=24, AW=12)
REQ-035 Reset: PAN_OUT all 0x4000, PAN_VALID=0, BUSY=0, OVERRUN=0.
REQ-036 Square, DEPTH=0xFFFF, RATE=0, SPREAD=0x8000, strobe at T -> PAN_VALID at T+14; ch0,ch2=0x7FFF; ch1,ch3=0x0000.
REQ-037 Ramp, DEPTH=0xFFFF, RATE=0x800000: strobe 1 -> all 0x4000; strobe 2 (acc wraps to 0) -> all 0x0000.
REQ-038 Sine, DEPTH=0x8000, RATE=0, SPREAD=0x4000, sine.mem[0]=0, sine.mem[1024]=0x7FFF -> ch0=0x4000, ch1=0x5FFF.
REQ-039 EN=0 with any MODE/DEPTH -> all 0x4000; following EN=1 frame starts from acc=RATE.
REQ-040 Strobe at T+5 during a frame -> ignored, OVERRUN=1, PAN_VALID only at T+14 with first frame's values; RESET at T+7 -> no PAN_VALID, outputs 0x4000.

Source files
------------

// File: rtl/panner_pkg.sv
// Shared types and constants for the multi-channel auto-panner.
package panner_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_TRI    = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_RAMP   = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC    = 3'd1,
    LOOKUP = 3'd2,
    WAIT   = 3'd3,
    CALC   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [15:0] PAN_CENTER = 16'h4000;

  // Table contents: parabolic half-wave approximation of sine.
  // Entry 0 is 0, the quarter-period entry is 0x7FFF, and the second half is negated.
  function automatic logic signed [15:0] sine_word(input int idx, input int aw);
    longint half;
    longint p;
    longint mag;
    half = longint'(1) << (aw - 1);
    p    = longint'(idx) % half;
    mag  = (p * (half - p) * 64'sd32767 * 64'sd4) / (half * half);
    if (longint'(idx) >= half)
      return 16'(-mag);
    return 16'(mag);
  endfunction

endpackage

// File: rtl/multi_auto_panner_lfo_wave.sv
// Sine table with a registered read, plus waveform shaping of the registered phase.
module lfo_wave
  import panner_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic               clk,
  input  logic               rd_en,
  input  logic [15:0]        ph,
  input  mode_t              mode,
  output logic signed [15:0] wave
);

  logic signed [15:0] rom [2**AW];
  logic signed [15:0] rom_q;
  logic [15:0]        u_q;
  logic [15:0]        dbl;

  for (genvar i = 0; i < 2**AW; i++) begin : g_rom
    assign rom[i] = sine_word(i, AW);
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rom_q <= rom[ph[15 -: AW]];
      u_q   <= ph;
    end
  end

  assign dbl = {u_q[14:0], 1'b0};

  always_comb begin
    wave = rom_q;
    unique case (mode)
      MODE_SINE:   wave = rom_q;
      MODE_TRI:    wave = u_q[15] ? (16'h7FFF - dbl) : (dbl ^ 16'h8000);
      MODE_SQUARE: wave = u_q[15] ? 16'h8000 : 16'h7FFF;
      MODE_RAMP:   wave = u_q ^ 16'h8000;
    endcase
  end

endmodule

// File: rtl/multi_auto_panner.sv
// Auto-panner: one LFO phase accumulator, channels processed serially through a
// shared table lookup and a single multiplier; results published together.
module multi_auto_panner
  import panner_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PW  = 24,
  parameter int AW  = 12
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SAMPLE_STB,
  input  logic              EN,
  input  logic [1:0]        MODE,
  input  logic [PW-1:0]     RATE,
  input  logic [15:0]       DEPTH,
  input  logic [15:0]       SPREAD,
  output logic [16*NCH-1:0] PAN_OUT,
  output logic              PAN_VALID,
  output logic              BUSY,
  output logic              OVERRUN
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  state_t             state, state_nx;
  logic [PW-1:0]      acc;
  logic [CW-1:0]      ch;
  logic [15:0]        offs;
  logic               en_q;
  mode_t              mode_q;
  logic [15:0]        depth_q;
  logic [15:0]        spread_q;
  logic [15:0]        ph;
  logic signed [15:0] wave;
  logic signed [32:0] prod;
  logic signed [15:0] off_q;
  logic signed [17:0] pan_sum;
  logic [15:0]        pan_c;
  logic [15:0]        shadow [NCH];
  logic [15:0]        pan_q  [NCH];

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (SAMPLE_STB) state_nx = ACC;
      ACC:     state_nx = LOOKUP;
      LOOKUP:  state_nx = WAIT;
      WAIT:    state_nx = CALC;
      CALC:    state_nx = (ch == LAST) ? DONE : LOOKUP;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign BUSY = (state != IDLE);
  // Per-channel phase offset is accumulated (offs = c*SPREAD) rather than multiplied.
  assign ph   = acc[PW-1 -: 16] + offs;

  lfo_wave #(.AW(AW)) u_wave (
    .clk   (CLK),
    .rd_en (state == LOOKUP),
    .ph    (ph),
    .mode  (mode_q),
    .wave  (wave)
  );

  assign prod    = $signed(wave) * $signed({1'b0, depth_q});
  assign pan_sum = 18'sh04000 + 18'(off_q);

  always_comb begin
    pan_c = PAN_CENTER;
    if (en_q) begin
      if (pan_sum[17])                 pan_c = 16'h0000;
      else if (pan_sum[16:15] != 2'b0) pan_c = 16'h7FFF;
      else                             pan_c = pan_sum[15:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc       <= '0;
      ch        <= '0;
      offs      <= '0;
      en_q      <= 1'b0;
      mode_q    <= MODE_SINE;
      depth_q   <= '0;
      spread_q  <= '0;
      off_q     <= '0;
      PAN_VALID <= 1'b0;
      OVERRUN   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= PAN_CENTER;
        pan_q[i]  <= PAN_CENTER;
      end
    end else begin
      PAN_VALID <= 1'b0;
      if (SAMPLE_STB && state != IDLE) OVERRUN <= 1'b1;
      unique case (state)
        ACC: begin
          en_q     <= EN;
          mode_q   <= mode_t'(MODE);
          depth_q  <= DEPTH;
          spread_q <= SPREAD;
          acc      <= EN ? acc + RATE : '0;
          ch       <= '0;
          offs     <= '0;
        end
        WAIT: off_q <= 16'(prod >>> 17);
        CALC: begin
          shadow[ch] <= pan_c;
          ch         <= ch + 1'b1;
          offs       <= offs + spread_q;
          // Outputs load on entry to DONE so PAN_OUT is already new while PAN_VALID is high.
          if (ch == LAST) begin
            PAN_VALID <= 1'b1;
            for (int i = 0; i < NCH; i++)
              pan_q[i] <= (i == int'(ch)) ? pan_c : shadow[i];
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_out
    assign PAN_OUT[16*i +: 16] = pan_q[i];
  end

endmodule
